// File: rtl/seven_segment_counter_mux_if.sv
// Control inputs and display/count outputs of the multiplexed 7-segment counter.
// The master drives the controls; the slave (the counter) drives the results.
interface seven_segment_counter_mux_if #(
  parameter int NDIG = 2,
  parameter int DW   = 7
);
  logic              enable;
  logic              up;
  logic              dec;
  logic              load;
  logic [4*NDIG-1:0] load_value;
  logic              blank_lz;
  logic [4*NDIG-1:0] count;
  logic              wrap;
  logic [DW-1:0]     led_port;
  logic [NDIG-1:0]   sel;

  modport master (
    output enable, up, dec, load, load_value, blank_lz,
    input  count, wrap, led_port, sel
  );

  modport slave (
    input  enable, up, dec, load, load_value, blank_lz,
    output count, wrap, led_port, sel
  );
endinterface

// File: rtl/seven_segment_counter_mux.sv
// N-digit hex/BCD up/down counter with tick divider, parallel load and a
// time-multiplexed 7-segment display stage with optional leading-zero blanking.
module seven_segment_counter_mux #(
  parameter int NDIG     = 2,
  parameter int DW       = 7,
  parameter int TICK_DIV = 12000000,
  parameter int SCAN_DIV = 120000
) (
  input logic                   clk,
  input logic                   reset,
  seven_segment_counter_mux_if.slave bus
);
  localparam int CW = 4 * NDIG;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [TW-1:0]   tdiv_q, tdiv_d;
  logic [SW-1:0]   sdiv_q, sdiv_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   count_q, count_d;
  logic            wrap_q, wrap_d;
  logic [NDIG-1:0] sel_q, sel_d;
  logic [DW-1:0]   led_q, led_d;
  logic            tick;
  logic [NDIG-1:0] blank;
  logic [3:0]      shown;

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      default: seg = 7'h71;
    endcase
  endfunction

  assign tick = bus.enable && (tdiv_q == TW'(TICK_DIV - 1));

  // Counter: carry/borrow ripples from digit 0; whatever leaves the top digit is the wrap.
  always_comb begin : count_logic
    logic [3:0] nib;
    logic       carry;
    nib     = '0;
    carry   = 1'b1;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (!bus.enable || tick) tdiv_d = '0;
    else                     tdiv_d = tdiv_q + 1'b1;

    if (bus.load) begin
      tdiv_d = '0;
      for (int unsigned i = 0; i < NDIG; i++) begin
        nib = bus.load_value[4*i +: 4];
        count_d[4*i +: 4] = (bus.dec && nib > 4'd9) ? 4'd9 : nib;
      end
    end else if (tick) begin
      for (int unsigned i = 0; i < NDIG; i++) begin
        nib = count_q[4*i +: 4];
        if (carry) begin
          if (bus.up) begin
            if (bus.dec ? (nib >= 4'd9) : (nib == 4'hF)) begin
              nib = 4'd0;
            end else begin
              nib   = nib + 4'd1;
              carry = 1'b0;
            end
          end else begin
            if (nib == 4'd0) begin
              nib = bus.dec ? 4'd9 : 4'hF;
            end else if (bus.dec && nib > 4'd9) begin
              nib   = 4'd9;
              carry = 1'b0;
            end else begin
              nib   = nib - 4'd1;
              carry = 1'b0;
            end
          end
        end
        count_d[4*i +: 4] = nib;
      end
      wrap_d = carry;
    end
  end

  always_comb begin
    sdiv_d = sdiv_q + 1'b1;
    idx_d  = idx_q;
    if (sdiv_q == SW'(SCAN_DIV - 1)) begin
      sdiv_d = '0;
      idx_d  = (idx_q == IW'(NDIG - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Scan from the top digit down so "all higher digits zero" accumulates in one pass.
  always_comb begin : blank_logic
    logic allz;
    int unsigned i;
    allz  = 1'b1;
    blank = '0;
    i     = 0;
    for (int unsigned k = 0; k < NDIG; k++) begin
      i        = NDIG - 1 - k;
      allz     = allz && (count_q[4*i +: 4] == 4'd0);
      blank[i] = bus.blank_lz && allz && (i != 0);
    end
  end

  always_comb begin
    shown = count_q[4*idx_q +: 4];
    sel_d = NDIG'(1) << idx_q;
    led_d = blank[idx_q] ? '0 : DW'(seg(shown));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tdiv_q  <= '0;
      sdiv_q  <= '0;
      idx_q   <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      sel_q   <= '0;
      led_q   <= '0;
    end else begin
      tdiv_q  <= tdiv_d;
      sdiv_q  <= sdiv_d;
      idx_q   <= idx_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      sel_q   <= sel_d;
      led_q   <= led_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.wrap     = wrap_q;
  assign bus.sel      = sel_q;
  assign bus.led_port = led_q;
endmodule

// File: tb/tb_seven_segment_counter_mux.sv
// Directed and randomized checks of seven_segment_counter_mux against a
// value-level reference model (NDIG=2, TICK_DIV=4, SCAN_DIV=3).
module tb_seven_segment_counter_mux;
  localparam int NDIG = 2;
  localparam int DW   = 7;
  localparam int TD   = 4;
  localparam int SD   = 3;
  localparam int MAXV = (1 << (4 * NDIG)) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seven_segment_counter_mux_if #(.NDIG(NDIG), .DW(DW)) bus ();

  seven_segment_counter_mux #(
    .NDIG(NDIG), .DW(DW), .TICK_DIV(TD), .SCAN_DIV(SD)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [6:0] PAT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference state: count as an integer, enabled cycles since last step,
  // and edges since reset (scan position derives from it arithmetically).
  int              m_cnt;
  int              m_phase;
  int              m_t;
  logic            m_wrap;
  logic [NDIG-1:0] m_sel;
  logic [DW-1:0]   m_led;

  function automatic int dig(input int v, input int i);
    return (v >> (4 * i)) & 15;
  endfunction

  function automatic int bcd_inc(input int v, output bit w);
    int r = v;
    bit done = 0;
    for (int i = 0; i < NDIG; i++) begin
      if (!done) begin
        if (dig(r, i) < 9) begin
          r = r + (1 << (4 * i));
          done = 1;
        end else begin
          r = r & ~(15 << (4 * i));
        end
      end
    end
    w = !done;
    return r;
  endfunction

  function automatic int bcd_dec(input int v, output bit w);
    int r = v;
    bit done = 0;
    for (int i = 0; i < NDIG; i++) begin
      if (!done) begin
        if (dig(r, i) == 0) begin
          r = r | (9 << (4 * i));
        end else if (dig(r, i) > 9) begin
          r = (r & ~(15 << (4 * i))) | (9 << (4 * i));
          done = 1;
        end else begin
          r = r - (1 << (4 * i));
          done = 1;
        end
      end
    end
    w = !done;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model by one edge using the inputs currently driven, then clock the DUT and compare.
  task automatic cycle();
    int  idx, v;
    bit  w, blank;
    idx   = (m_t / SD) % NDIG;
    blank = (idx >= 1) && bus.blank_lz && ((m_cnt >> (4 * idx)) == 0);
    if (reset) begin
      m_cnt = 0; m_phase = 0; m_t = 0;
      m_wrap = 1'b0; m_sel = '0; m_led = '0;
    end else begin
      m_sel = NDIG'(1 << idx);
      m_led = blank ? '0 : DW'(PAT[dig(m_cnt, idx)]);
      m_t++;
      m_wrap = 1'b0;
      if (bus.load) begin
        v = 0;
        for (int i = 0; i < NDIG; i++) begin
          int d = (int'(bus.load_value) >> (4 * i)) & 15;
          if (bus.dec && d > 9) d = 9;
          v = v | (d << (4 * i));
        end
        m_cnt = v;
        m_phase = 0;
      end else if (!bus.enable) begin
        m_phase = 0;
      end else if (m_phase == TD - 1) begin
        m_phase = 0;
        if (bus.dec) begin
          m_cnt = bus.up ? bcd_inc(m_cnt, w) : bcd_dec(m_cnt, w);
        end else if (bus.up) begin
          w = (m_cnt == MAXV);
          m_cnt = (m_cnt + 1) % (MAXV + 1);
        end else begin
          w = (m_cnt == 0);
          m_cnt = (m_cnt == 0) ? MAXV : m_cnt - 1;
        end
        m_wrap = w;
      end else begin
        m_phase++;
      end
    end
    @(posedge clk);
    #1;
    chk("count", 32'(bus.count), 32'(m_cnt));
    chk("wrap", 32'(bus.wrap), 32'(m_wrap));
    chk("sel", 32'(bus.sel), 32'(m_sel));
    chk("led_port", 32'(bus.led_port), 32'(m_led));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic do_load(input logic [4*NDIG-1:0] v);
    bus.load = 1'b1;
    bus.load_value = v;
    cycle();
    bus.load = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.enable = 1'b0; bus.up = 1'b1; bus.dec = 1'b0;
    bus.load = 1'b0; bus.load_value = '0; bus.blank_lz = 1'b0;
    m_cnt = 0; m_phase = 0; m_t = 0;
    m_wrap = 1'b0; m_sel = '0; m_led = '0;

    run(2);
    chk("reset_count", 32'(bus.count), 32'h0);
    chk("reset_sel", 32'(bus.sel), 32'h0);

    // Free-running hex up count
    reset = 1'b0;
    bus.enable = 1'b1;
    cycle();
    chk("first_sel", 32'(bus.sel), 32'h1);
    chk("first_led", 32'(bus.led_port), 32'h3F);
    run(2);
    chk("count_before_tick", 32'(bus.count), 32'h00);
    cycle();
    chk("count_first_tick", 32'(bus.count), 32'h01);
    run(4);
    chk("count_second_tick", 32'(bus.count), 32'h02);

    // Hex wrap up and down
    do_load(8'hFF);
    run(4);
    chk("hex_up_wrap_count", 32'(bus.count), 32'h00);
    chk("hex_up_wrap_pulse", 32'(bus.wrap), 32'h1);
    bus.up = 1'b0;
    run(4);
    chk("hex_dn_wrap_count", 32'(bus.count), 32'hFF);
    chk("hex_dn_wrap_pulse", 32'(bus.wrap), 32'h1);
    cycle();
    chk("wrap_one_cycle", 32'(bus.wrap), 32'h0);

    // BCD
    bus.dec = 1'b1; bus.up = 1'b1;
    do_load(8'h99);
    run(4);
    chk("bcd_up_wrap", 32'(bus.count), 32'h00);
    do_load(8'h09);
    run(4);
    chk("bcd_carry", 32'(bus.count), 32'h10);
    bus.up = 1'b0;
    run(4);
    chk("bcd_borrow", 32'(bus.count), 32'h09);
    do_load(8'h3C);
    chk("bcd_clamp", 32'(bus.count), 32'h39);
    do_load(8'h00);
    run(4);
    chk("bcd_dn_wrap", 32'(bus.count), 32'h99);
    chk("bcd_dn_wrap_pulse", 32'(bus.wrap), 32'h1);

    // Scan with frozen count
    bus.enable = 1'b0; bus.dec = 1'b0;
    do_load(8'h4A);
    run(12);

    // Leading-zero blanking
    bus.blank_lz = 1'b1;
    do_load(8'h05);
    run(7);
    do_load(8'h00);
    run(7);
    bus.blank_lz = 1'b0;
    run(7);

    // Load coinciding with a tick that would wrap
    bus.enable = 1'b1; bus.up = 1'b1;
    do_load(8'hFF);
    run(3);
    do_load(8'h12);
    chk("load_over_tick", 32'(bus.count), 32'h12);
    chk("load_no_wrap", 32'(bus.wrap), 32'h0);

    // Reset mid-frame
    run(4);
    reset = 1'b1;
    cycle();
    chk("midreset_count", 32'(bus.count), 32'h0);
    chk("midreset_sel", 32'(bus.sel), 32'h0);
    chk("midreset_led", 32'(bus.led_port), 32'h0);
    reset = 1'b0;

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      reset          = ($urandom_range(0, 199) == 0);
      bus.enable     = ($urandom_range(0, 7) != 0);
      bus.up         = 1'($urandom_range(0, 1));
      bus.dec        = ($urandom_range(0, 3) == 0) ? ~bus.dec : bus.dec;
      bus.load       = ($urandom_range(0, 15) == 0);
      bus.load_value = 8'($urandom);
      bus.blank_lz   = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/seven_segment_counter_mux.md
# seven_segment_counter_mux

Parametrised N-digit multiplexed 7-segment counter/display controller for the Alhambra II board. It holds a per-digit hex or BCD up/down counter advanced by an internal tick divider and supports a parallel load. It time-multiplexes the digits onto one shared segment bus with a one-hot digit select and optional leading-zero blanking. It is the drop-in display engine for any top level that needs more than two digits, down counting, decimal mode or a preset value.

## Interface
- NDIG, 2, number of digits (≥1); digit 0 is least significant
- DW, 7, segment bus width; led_port[0]=a … led_port[6]=g, 1 = segment lit
- TICK_DIV, 12000000, clk cycles per count step (1 Hz at 12 MHz); ≥2
- SCAN_DIV, 120000, clk cycles each digit stays selected; ≥1

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  1 = tick divider runs and count advances; 0 = divider held at 0, count frozen
- up  in  1  1 = increment, 0 = decrement on tick
- dec  in  1  1 = BCD digits (0–9), 0 = hex digits (0–F)
- load  in  1  load load_value on next edge
- load_value  in  4*NDIG  preset, nibble i = digit i
- blank_lz  in  1  1 = blank leading zero digits
- count  out  4*NDIG  current count, nibble per digit, registered
- wrap  out  1  one-cycle pulse when count wraps
- led_port  out  DW  segment pattern of the selected digit, registered
- sel  out  NDIG  one-hot digit select, active high, registered

## Operation
- Reset: count=0, wrap=0, led_port=0, sel=0, tick divider=0, scan divider=0, scan index=0.
- Tick divider: counts 0..TICK_DIV-1 while enable=1. A tick occurs in any cycle where the divider equals TICK_DIV-1. When enable=0, the divider is forced to 0.
- Load has priority over tick. On load, count←load_value and the tick divider←0, with no wrap pulse. With dec=1, any loaded nibble >9 is clamped to 9.
- Increment (tick, up=1), ripple from digit 0:
  - hex: digit F→0 with carry.
  - dec: digit ≥9→0 with carry.
  - Otherwise the digit+1 and the carry stops.
- Decrement (tick, up=0):
  - digit 0 → F (hex) or 9 (dec), with borrow.
  - dec digit >9 → 9, no borrow.
  - Otherwise digit−1.
- wrap=1 for exactly the cycle following an edge where carry or borrow leaves digit NDIG-1 (all-max→0 or 0→all-max).
- A change of dec does not convert the held value. The rules above apply from the next tick.
- Scan: the scan divider counts 0..SCAN_DIV-1 continuously, independent of enable. At SCAN_DIV-1 the scan index advances by one and wraps NDIG-1→0.
- Display stage (registered every cycle):
  - sel←one-hot(index).
  - led_port←pattern(digit[index]), or 0 if the digit is blanked.
- Patterns 0–F: 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
- Blanking: digit i≥1 is blanked when blank_lz=1 and digits NDIG-1..i are all zero. Digit 0 is never blanked.

## Timing
- With enable=1 from the first cycle after reset release, count changes on the TICK_DIV-th edge and every TICK_DIV edges after that.
- count and wrap update on the same edge; wrap is visible for one cycle.
- led_port and sel lag the scan index and count by one cycle.
- The first display update occurs one edge after reset release: sel=…01, led_port=3F.
- Each digit stays selected for SCAN_DIV cycles, so the full frame is NDIG·SCAN_DIV cycles.
- Reset mid-operation returns all state to reset values on the next edge, overriding load and tick.
- load and tick in the same cycle: load wins, no wrap.
- enable dropping mid-period discards the partial period. The next tick is TICK_DIV enabled cycles later.

## Test plan
All cases use NDIG=2, TICK_DIV=4, SCAN_DIV=3.
- Reset, then enable=1, up=1, dec=0 → count 00 until the 4th edge, then 01, 02 every 4 cycles; wrap stays 0.
- Hex wrap:
  - load 0xFF, up=1 → after 4 cycles count=00 and wrap pulses 1 cycle.
  - up=0 from 00 → FF with a wrap pulse.
- BCD:
  - load 0x99, up → 00 + wrap; load 0x09, up → 10.
  - up=0 from 10 → 09.
  - load 0x3C → count 39.
  - load 0x00, up=0 → 99 + wrap.
- Scan: hold 0x4A (enable=0, dec=0) → sel 01 for 3 cycles with led_port 77, then sel 10 with led_port 66, then repeat.
- Blanking: count 05, blank_lz=1 → led_port 00 when sel=10 and 6D when sel=01. Count 00 → sel=01 shows 3F. blank_lz=0 → sel=10 shows 3F.
- Assert load and tick together with load_value=0x12 → count 12, no wrap. Assert reset mid-frame → next edge count=00, sel/led_port=0, wrap=0.
